spi_cmd_controller: RTL and testbench

- Command sequencer for the SPI slave byte interface, on the INNER_CLK domain of the accelerator.
- Decodes byte frames received over SPI into tensor-memory writes and reads, status reads, and compute-start pulses.
- Drives the slave's TX_BYTE/WE reload port so that each response byte is ready before the host clocks the next byte.
- Sits between the SPI slave and the weight/input/result buffers and compute core.

---
 rtl/spi_cmd_controller.sv | 277 +++++++++++++++++++++++++++
 tb/tb_spi_cmd_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_controller.sv
`default_nettype none
// ============================================================================
//  Module   : spi_cmd_controller
//  Purpose  : Decodes SPI slave byte frames into buffer writes/reads, status
//             reads and compute-start pulses; reloads the slave TX byte.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_controller #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CS_IN,
    input  logic              RX_DONE,
    input  logic [7:0]        RX_BYTE,
    output logic [7:0]        TX_BYTE,
    output logic              WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_WDATA,
    output logic              MEM_WE,
    output logic              MEM_RE,
    input  logic [7:0]        MEM_RDATA,
    input  logic              BUSY,
    output logic              START,
    output logic              ERR
);

    localparam logic [7:0] C_OP_NOP    = 8'h00;
    localparam logic [7:0] C_OP_WRITE  = 8'h01;
    localparam logic [7:0] C_OP_READ   = 8'h02;
    localparam logic [7:0] C_OP_STATUS = 8'h03;
    localparam logic [7:0] C_OP_START  = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_LEN    = 3'd2,
        S_WDATA  = 3'd3,
        S_RFETCH = 3'd4,
        S_RWAIT  = 3'd5,
        S_RDATA  = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_rx_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_rx_prev;
    logic                   r_cs_prev;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rx_sync <= '0;
            r_cs_sync <= '0;
            r_rx_prev <= 1'b0;
            r_cs_prev <= 1'b0;
        end else begin
            r_rx_sync <= {r_rx_sync[SYNC_STAGES-2:0], RX_DONE};
            r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], CS_IN};
            r_rx_prev <= r_rx_sync[SYNC_STAGES-1];
            r_cs_prev <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic w_cs;
    logic w_rx_stb;
    logic w_cs_fall;
    logic w_rx_valid;

    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_rx_stb   = r_rx_sync[SYNC_STAGES-1] & ~r_rx_prev;
    assign w_cs_fall  = r_cs_prev & ~w_cs;
    // Bytes arriving outside an active frame are dropped.
    assign w_rx_valid = w_rx_stb & w_cs;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_remaining;
    logic              r_is_read;
    logic [7:0]        r_tx;
    logic              r_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_mem_we;
    logic              r_mem_re;
    logic              r_start;
    logic              r_err;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_remaining_nxt;
    logic              w_is_read_nxt;
    logic [7:0]        w_tx_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [7:0]        w_mem_wdata_nxt;
    logic              w_mem_we_nxt;
    logic              w_mem_re_nxt;
    logic              w_start_nxt;
    logic              w_err_nxt;

    logic [ADDR_W-1:0] w_addr_inc;
    logic [7:0]        w_rem_dec;

    assign w_addr_inc = r_addr + ADDR_W'(1);
    assign w_rem_dec  = r_remaining - 8'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= 8'h00;
            r_is_read   <= 1'b0;
            r_tx        <= 8'h00;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_start     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_remaining <= w_remaining_nxt;
            r_is_read   <= w_is_read_nxt;
            r_tx        <= w_tx_nxt;
            r_we        <= w_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_re    <= w_mem_re_nxt;
            r_start     <= w_start_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_remaining_nxt = r_remaining;
        w_is_read_nxt   = r_is_read;
        w_tx_nxt        = r_tx;
        w_we_nxt        = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_we_nxt    = 1'b0;
        w_mem_re_nxt    = 1'b0;
        w_start_nxt     = 1'b0;
        w_err_nxt       = r_err;

        if (w_cs_fall && (r_state != S_IDLE)) begin
            // A frame cut short during a data phase is a protocol error.
            w_state_nxt = S_IDLE;
            if ((r_state inside {S_WDATA, S_RFETCH, S_RWAIT, S_RDATA}) &&
                (r_remaining != 8'h00)) begin
                w_err_nxt = 1'b1;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_rx_valid) begin
                        w_we_nxt = 1'b1;
                        w_tx_nxt = 8'h00;
                        case (RX_BYTE)
                            C_OP_NOP: ;
                            C_OP_WRITE: begin
                                w_is_read_nxt = 1'b0;
                                w_state_nxt   = S_ADDR;
                            end
                            C_OP_READ: begin
                                w_is_read_nxt = 1'b1;
                                w_state_nxt   = S_ADDR;
                            end
                            C_OP_STATUS: begin
                                w_tx_nxt  = {6'b0, BUSY, r_err};
                                w_err_nxt = 1'b0;
                            end
                            C_OP_START: begin
                                if (!BUSY) begin
                                    w_start_nxt = 1'b1;
                                end else begin
                                    w_err_nxt = 1'b1;
                                end
                            end
                            default: w_err_nxt = 1'b1;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (w_rx_valid) begin
                        w_addr_nxt  = RX_BYTE[ADDR_W-1:0];
                        w_we_nxt    = 1'b1;
                        w_tx_nxt    = 8'h00;
                        w_state_nxt = S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_rx_valid) begin
                        w_remaining_nxt = RX_BYTE;
                        if (RX_BYTE == 8'h00) begin
                            w_we_nxt    = 1'b1;
                            w_tx_nxt    = 8'h00;
                            w_state_nxt = S_IDLE;
                        end else if (r_is_read) begin
                            // The WE for this byte comes from RWAIT with read data.
                            w_mem_re_nxt   = 1'b1;
                            w_mem_addr_nxt = r_addr;
                            w_state_nxt    = S_RFETCH;
                        end else begin
                            w_we_nxt    = 1'b1;
                            w_tx_nxt    = 8'h00;
                            w_state_nxt = S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (w_rx_valid) begin
                        w_mem_we_nxt    = 1'b1;
                        w_mem_wdata_nxt = RX_BYTE;
                        w_mem_addr_nxt  = r_addr;
                        w_addr_nxt      = w_addr_inc;
                        w_remaining_nxt = w_rem_dec;
                        w_we_nxt        = 1'b1;
                        w_tx_nxt        = 8'h00;
                        if (w_rem_dec == 8'h00) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_RFETCH: begin
                    w_state_nxt = S_RWAIT;
                end
                S_RWAIT: begin
                    w_tx_nxt    = MEM_RDATA;
                    w_we_nxt    = 1'b1;
                    w_state_nxt = S_RDATA;
                end
                S_RDATA: begin
                    if (w_rx_valid) begin
                        w_addr_nxt      = w_addr_inc;
                        w_remaining_nxt = w_rem_dec;
                        if (w_rem_dec == 8'h00) begin
                            w_we_nxt    = 1'b1;
                            w_tx_nxt    = 8'h00;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_mem_re_nxt   = 1'b1;
                            w_mem_addr_nxt = w_addr_inc;
                            w_state_nxt    = S_RFETCH;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign TX_BYTE   = r_tx;
    assign WE        = r_we;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_WDATA = r_mem_wdata;
    assign MEM_WE    = r_mem_we;
    assign MEM_RE    = r_mem_re;
    assign START     = r_start;
    assign ERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_cmd_controller
//  Purpose  : Scoreboard bench for spi_cmd_controller with a frame-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_in = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic       we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata;
    logic       busy = 1'b0;
    logic       start;
    logic       err;

    spi_cmd_controller #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .CS_IN     (cs_in),
        .RX_DONE   (rx_done),
        .RX_BYTE   (rx_byte),
        .TX_BYTE   (tx_byte),
        .WE        (we),
        .MEM_ADDR  (mem_addr),
        .MEM_WDATA (mem_wdata),
        .MEM_WE    (mem_we),
        .MEM_RE    (mem_re),
        .MEM_RDATA (mem_rdata),
        .BUSY      (busy),
        .START     (start),
        .ERR       (err)
    );

    always #5 clk = ~clk;

    // Buffer the DUT talks to; loaded through a side port before use.
    logic [7:0] dev_mem [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = 8'h00;
    logic [7:0] pl_data = 8'h00;

    always @(posedge clk) begin
        if (pl_en) dev_mem[pl_addr] <= pl_data;
        else if (mem_we) dev_mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= dev_mem[mem_addr];
    end

    // Reference model state and scoreboard queues
    logic [7:0]  ref_mem [256];
    logic        model_err = 1'b0;
    logic [7:0]  exp_tx [$];
    logic [15:0] exp_wr [$];
    int          exp_start = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an output event.
    initial begin
        logic [1:0]  re_hist;
        logic [7:0]  e8;
        logic [15:0] e16;
        re_hist = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                re_hist = 2'b00;
            end else begin
                if (re_hist[1]) chk("re_to_we_2cyc", {31'b0, we}, 32'd1);
                re_hist = {re_hist[0], mem_re};
                if (we) begin
                    if (exp_tx.size() == 0) chk("tx_unexpected_we", {24'b0, tx_byte}, 32'hFFFF_FFFF);
                    else begin
                        e8 = exp_tx.pop_front();
                        chk("tx_byte", {24'b0, tx_byte}, {24'b0, e8});
                    end
                end
                if (mem_we) begin
                    if (exp_wr.size() == 0) chk("unexpected_mem_we", {16'b0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
                    else begin
                        e16 = exp_wr.pop_front();
                        chk("mem_write", {16'b0, mem_addr, mem_wdata}, {16'b0, e16});
                    end
                end
                if (start) begin
                    chk("start_expected", (exp_start > 0) ? 32'd1 : 32'd0, 32'd1);
                    if (exp_start > 0) exp_start--;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Host-side stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte = b;
        rx_done = 1'b1;
        repeat (6) @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic cs_up();
        @(posedge clk); #1 cs_in = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic cs_down();
        @(posedge clk); #1 cs_in = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1 pl_en = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d [$]);
        cs_up();
        exp_tx.push_back(8'h00); send_byte(8'h01);
        exp_tx.push_back(8'h00); send_byte(a);
        exp_tx.push_back(8'h00); send_byte(8'(d.size()));
        for (int i = 0; i < d.size(); i++) begin
            logic [7:0] wa;
            wa = a + 8'(i);
            exp_wr.push_back({wa, d[i]});
            ref_mem[wa] = d[i];
            exp_tx.push_back(8'h00);
            send_byte(d[i]);
        end
        cs_down();
    endtask

    task automatic do_read(input logic [7:0] a, input int len);
        cs_up();
        exp_tx.push_back(8'h00); send_byte(8'h02);
        exp_tx.push_back(8'h00); send_byte(a);
        exp_tx.push_back(len == 0 ? 8'h00 : ref_mem[a]);
        send_byte(8'(len));
        for (int k = 0; k < len; k++) begin
            logic [7:0] ra;
            ra = a + 8'(k + 1);
            exp_tx.push_back(k == len - 1 ? 8'h00 : ref_mem[ra]);
            send_byte(8'($urandom_range(0, 255)));
        end
        cs_down();
    endtask

    task automatic do_op(input logic [7:0] op);
        logic [7:0] t;
        t = 8'h00;
        case (op)
            8'h00: ;
            8'h03: begin t = {6'b0, busy, model_err}; model_err = 1'b0; end
            8'h04: if (!busy) exp_start++; else model_err = 1'b1;
            default: model_err = 1'b1;
        endcase
        cs_up();
        exp_tx.push_back(t);
        send_byte(op);
        cs_down();
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] wd [$];
        int         sel;
        int         len;

        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom_range(0, 255)));
        repeat (2) @(posedge clk);
        chk("reset_outputs", {3'b0, tx_byte, we, mem_addr, mem_wdata, mem_we, mem_re, start, err}, 32'd0);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        do_op(8'h03);
        chk("err_after_reset", {31'b0, err}, 32'd0);

        wd = '{8'hAA, 8'hBB, 8'hCC};
        do_write(8'h10, wd);

        preload(8'hFE, 8'h5A);
        preload(8'hFF, 8'h66);
        preload(8'h00, 8'h77);
        do_read(8'hFE, 3);

        busy = 1'b0; do_op(8'h04);
        busy = 1'b1; do_op(8'h04);
        chk("err_after_busy_start", {31'b0, err}, {31'b0, model_err});
        do_op(8'h03);
        do_op(8'h03);
        busy = 1'b0;

        do_op(8'h7E);
        chk("err_after_bad_op", {31'b0, err}, {31'b0, model_err});
        do_op(8'h03);
        do_op(8'h03);

        // Write of 4 aborted after 2 data bytes
        cs_up();
        exp_tx.push_back(8'h00); send_byte(8'h01);
        exp_tx.push_back(8'h00); send_byte(8'h40);
        exp_tx.push_back(8'h00); send_byte(8'h04);
        for (int i = 0; i < 2; i++) begin
            exp_wr.push_back({8'(8'h40 + i), 8'(8'hD0 + i)});
            ref_mem[8'(8'h40 + i)] = 8'(8'hD0 + i);
            exp_tx.push_back(8'h00);
            send_byte(8'(8'hD0 + i));
        end
        model_err = 1'b1;
        cs_down();
        chk("err_after_write_abort", {31'b0, err}, {31'b0, model_err});
        do_op(8'h03);

        // Abort in ADDR leaves ERR untouched
        cs_up();
        exp_tx.push_back(8'h00); send_byte(8'h02);
        cs_down();
        chk("err_after_addr_abort", {31'b0, err}, {31'b0, model_err});

        // Byte with CS inactive is ignored
        send_byte(8'h7E);
        chk("err_cs_low_byte", {31'b0, err}, {31'b0, model_err});

        // Randomized command mix
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 6);
            busy = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 5);
            case (sel)
                0: begin
                    wd.delete();
                    for (int i = 0; i < len; i++) wd.push_back(8'($urandom_range(0, 255)));
                    do_write(8'($urandom_range(0, 255)), wd);
                end
                1, 2: do_read(8'($urandom_range(0, 255)), len);
                3: do_op(8'h03);
                4: do_op(8'h04);
                5: do_op(8'h00);
                default: do_op(8'($urandom_range(5, 255)));
            endcase
            chk("err_flag", {31'b0, err}, {31'b0, model_err});
        end
        busy = 1'b0;

        // Reset in the middle of a read
        cs_up();
        exp_tx.push_back(8'h00); send_byte(8'h02);
        exp_tx.push_back(8'h00); send_byte(8'hFE);
        exp_tx.push_back(ref_mem[8'hFE]); send_byte(8'h03);
        @(posedge clk); #1;
        rx_byte = 8'h00; rx_done = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {3'b0, tx_byte, we, mem_addr, mem_wdata, mem_we, mem_re, start, err}, 32'd0);
        exp_tx.delete();
        exp_wr.delete();
        exp_start = 0;
        model_err = 1'b0;
        rx_done = 1'b0;
        cs_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        do_op(8'h03);

        repeat (10) @(posedge clk);
        chk("tx_queue_drained", exp_tx.size(), 32'd0);
        chk("wr_queue_drained", exp_wr.size(), 32'd0);
        chk("start_drained", exp_start, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
